// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - grant/host-state types and default widths for the BIST memory arbiter
package bist_pkg;

  localparam int BIST_ADDR_W = 8;
  localparam int BIST_DATA_W = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_BIST = 2'd1,
    GNT_HOST = 2'd2
  } gnt_e;

  typedef enum logic {
    H_IDLE = 1'b0,
    H_ACK  = 1'b1
  } host_state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Clear has priority over increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bist_mem_arbiter.sv
// rtl/bist_mem_arbiter.sv - BIST engine / JTAG host arbiter for the single-port test-vector SRAM
// Optional BIST_MEM_HOST_LOCK_EN: host is locked out for as long as bist_active is high.
module bist_mem_arbiter
  import bist_pkg::*;
#(
  parameter int ADDR_W  = BIST_ADDR_W,
  parameter int DATA_W  = BIST_DATA_W,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bist_rd,
  input  logic [ADDR_W-1:0]  bist_addr,
  output logic [DATA_W-1:0]  bist_data,
  input  logic               bist_active,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [ADDR_W-1:0]  host_addr,
  input  logic [DATA_W-1:0]  host_wdata,
  output logic               host_ack,
  output logic [DATA_W-1:0]  host_rdata,
  output logic [STALL_W-1:0] host_stall_cnt,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  gnt_e              gnt;
  gnt_e              rd_sel_q;
  host_state_e       state_q;
  logic              host_ack_q;
  logic              rd_we_q;
  logic [DATA_W-1:0] hold_q;
  logic              host_lock;
  logic              stall_inc;
  logic              stall_clr;

`ifdef BIST_MEM_HOST_LOCK_EN
  assign host_lock = bist_active;
`else
  logic unused_bist_active;
  assign unused_bist_active = bist_active;
  assign host_lock          = 1'b0;
`endif

  // Grant is held off during reset so the SRAM sees no access while rst_n is low.
  always_comb begin
    gnt = GNT_NONE;
    if (rst_n) begin
      if (bist_rd) begin
        gnt = GNT_BIST;
      end else if (host_req && (state_q == H_IDLE) && !host_lock) begin
        gnt = GNT_HOST;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt)
      GNT_BIST: begin
        mem_en   = 1'b1;
        mem_addr = bist_addr;
      end
      GNT_HOST: begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= H_IDLE;
      host_ack_q <= 1'b0;
      rd_sel_q   <= GNT_NONE;
      rd_we_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      rd_sel_q <= gnt;
      rd_we_q  <= host_we;
      if (rd_sel_q == GNT_BIST) begin
        hold_q <= mem_rdata;
      end
      case (state_q)
        H_IDLE: begin
          if (gnt == GNT_HOST) begin
            state_q    <= H_ACK;
            host_ack_q <= 1'b1;
          end
        end
        H_ACK: begin
          state_q    <= H_IDLE;
          host_ack_q <= 1'b0;
        end
        default: begin
          state_q    <= H_IDLE;
          host_ack_q <= 1'b0;
        end
      endcase
    end
  end

  // The SRAM read port is shared, so its output is steered by who owned the previous cycle.
  assign bist_data  = (rd_sel_q == GNT_BIST) ? mem_rdata : hold_q;
  assign host_rdata = ((rd_sel_q == GNT_HOST) && !rd_we_q) ? mem_rdata : '0;
  assign host_ack   = host_ack_q;

  assign stall_inc = host_req && (state_q == H_IDLE) && (gnt != GNT_HOST);
  assign stall_clr = (gnt == GNT_HOST);

  sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .clr_i (stall_clr),
    .cnt_o (host_stall_cnt)
  );

endmodule

// File: tb/tb_bist_mem_arbiter.sv
// tb/tb_bist_mem_arbiter.sv - directed and randomized checks of bist_mem_arbiter against a reference model
module tb_bist_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bist_rd;
  logic [7:0] bist_addr;
  logic [7:0] bist_data;
  logic       bist_active;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [7:0] host_stall_cnt;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] sram    [256];
  logic [7:0] ref_mem [256];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bist_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bist_rd        (bist_rd),
    .bist_addr      (bist_addr),
    .bist_data      (bist_data),
    .bist_active    (bist_active),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .host_stall_cnt (host_stall_cnt),
    .mem_en         (mem_en),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // 256x8 synchronous SRAM with a one-cycle registered read
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  task automatic drive(input logic b_rd, input logic [7:0] b_addr, input logic h_req,
                       input logic h_we, input logic [7:0] h_addr, input logic [7:0] h_wdata);
    bist_rd    = b_rd;
    bist_addr  = b_addr;
    host_req   = h_req;
    host_we    = h_we;
    host_addr  = h_addr;
    host_wdata = h_wdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bist_active = 1'b0;
    drive(1'b1, 8'h05, 1'b1, 1'b1, 8'h06, 8'h07);
    #10;
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", host_ack); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", host_rdata); end
    checks++; if (bist_data !== 8'h00) begin errors++; $display("FAIL reset_bist_data got=%h exp=00", bist_data); end
    checks++; if (host_stall_cnt !== 8'h00) begin errors++; $display("FAIL reset_stall got=%0d exp=0", host_stall_cnt); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem en=%b we=%b exp=0/0", mem_en, mem_we); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_host_write();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 8'hA5);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_ctl en=%b we=%b exp=1/1", mem_en, mem_we); end
    checks++; if (mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_mem_bus addr=%h data=%h exp=10/a5", mem_addr, mem_wdata); end
    ref_mem[8'h10] = 8'hA5;
    tick();
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got=%b exp=1", host_ack); end
    checks++; if (host_stall_cnt !== 8'h00) begin errors++; $display("FAIL wr_stall got=%0d exp=0", host_stall_cnt); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL wr_tail_not_granted mem_en=%b exp=0", mem_en); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got=%b exp=0", host_ack); end
  endtask

  task automatic test_host_read();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin errors++; $display("FAIL rd_mem en=%b we=%b addr=%h exp=1/0/10", mem_en, mem_we, mem_addr); end
    tick();
    checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got=%b exp=1", host_ack); end
    checks++; if (host_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got=%h exp=a5", host_rdata); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rd_data_idle got=%h exp=00", host_rdata); end
  endtask

  task automatic test_collision();
    drive(1'b1, 8'h10, 1'b1, 1'b1, 8'h20, 8'h3C);
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h10) begin errors++; $display("FAIL col_bist_wins we=%b addr=%h exp=0/10", mem_we, mem_addr); end
    tick();
    checks++; if (bist_data !== 8'hA5) begin errors++; $display("FAIL col_bist_data got=%h exp=a5", bist_data); end
    checks++; if (host_stall_cnt !== 8'd1) begin errors++; $display("FAIL col_stall got=%0d exp=1", host_stall_cnt); end
    drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL col_host_grant we=%b addr=%h data=%h exp=1/20/3c", mem_we, mem_addr, mem_wdata); end
    ref_mem[8'h20] = 8'h3C;
    tick();
    checks++; if (host_ack !== 1'b1 || host_stall_cnt !== 8'd0) begin errors++; $display("FAIL col_ack ack=%b stall=%0d exp=1/0", host_ack, host_stall_cnt); end
    checks++; if (bist_data !== 8'hA5) begin errors++; $display("FAIL col_bist_hold got=%h exp=a5", bist_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic test_starvation();
    int acks = 0;
    drive(1'b1, 8'h10, 1'b1, 1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (host_ack) acks++;
    end
    checks++; if (host_stall_cnt !== 8'd255) begin errors++; $display("FAIL starve_sat got=%0d exp=255", host_stall_cnt); end
    checks++; if (acks != 0) begin errors++; $display("FAIL starve_no_ack got=%0d exp=0", acks); end
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h20) begin errors++; $display("FAIL starve_grant en=%b addr=%h exp=1/20", mem_en, mem_addr); end
    tick();
    checks++; if (host_ack !== 1'b1 || host_rdata !== 8'h3C) begin errors++; $display("FAIL starve_ack ack=%b data=%h exp=1/3c", host_ack, host_rdata); end
    checks++; if (host_stall_cnt !== 8'd0) begin errors++; $display("FAIL starve_clear got=%0d exp=0", host_stall_cnt); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

`ifdef BIST_MEM_HOST_LOCK_EN
  task automatic test_lock();
    int grants = 0;
    bist_active = 1'b1;
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 10; i++) begin
      if (mem_en) grants++;
      tick();
    end
    checks++; if (grants != 0) begin errors++; $display("FAIL lock_no_grant got=%0d exp=0", grants); end
    checks++; if (host_stall_cnt !== 8'd10) begin errors++; $display("FAIL lock_stall got=%0d exp=10", host_stall_cnt); end
    bist_active = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("FAIL lock_release en=%b addr=%h exp=1/10", mem_en, mem_addr); end
    tick();
    checks++; if (host_ack !== 1'b1 || host_rdata !== 8'hA5) begin errors++; $display("FAIL lock_ack ack=%b data=%h exp=1/a5", host_ack, host_rdata); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask
`endif

  task automatic test_reset_mid_access();
    drive(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    checks++; if (host_ack !== 1'b1 || bist_data !== 8'hA5) begin errors++; $display("FAIL rst_pre ack=%b bist=%h exp=1/a5", host_ack, bist_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (host_ack !== 1'b0 || bist_data !== 8'h00) begin errors++; $display("FAIL rst_mid ack=%b bist=%h exp=0/00", host_ack, bist_data); end
    checks++; if (host_rdata !== 8'h00 || mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid_bus rdata=%h en=%b exp=00/0", host_rdata, mem_en); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    tick();
    checks++; if (host_ack !== 1'b1 || host_rdata !== 8'h3C) begin errors++; $display("FAIL rst_after ack=%b data=%h exp=1/3c", host_ack, host_rdata); end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  // Transaction-level model: memory contents, last engine read value, host request lifecycle.
  task automatic test_random();
    bit         pend      = 1'b0;
    bit         ack_phase = 1'b0;
    bit         lock;
    logic       p_we      = 1'b0;
    logic [7:0] p_addr    = 8'h00;
    logic [7:0] p_wdata   = 8'h00;
    logic [7:0] exp_bd    = 8'h00;
    logic [7:0] exp_hr    = 8'h00;
    int         stall     = 0;
    int         g;
    logic       b_rd;
    logic [7:0] b_addr;
    logic       h_req;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!pend && !ack_phase && ($urandom_range(0, 2) == 0)) begin
        pend    = 1'b1;
        p_we    = 1'($urandom_range(0, 1));
        p_addr  = 8'($urandom_range(0, 15));
        p_wdata = 8'($urandom);
      end
      h_req       = pend || ack_phase;
      b_rd        = ($urandom_range(0, 99) < 55);
      b_addr      = 8'($urandom_range(0, 15));
      bist_active = ($urandom_range(0, 3) == 0);
      drive(b_rd, b_addr, h_req, p_we, p_addr, p_wdata);
`ifdef BIST_MEM_HOST_LOCK_EN
      lock = bist_active;
`else
      lock = 1'b0;
`endif
      if (b_rd) g = 1;
      else if (pend && !ack_phase && !lock) g = 2;
      else g = 0;
      checks++;
      if (mem_en !== (g != 0)) begin errors++; $display("FAIL rnd_mem_en cyc=%0d got=%b exp=%b", cyc, mem_en, (g != 0)); end
      if (g == 1) begin
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== b_addr) begin errors++; $display("FAIL rnd_bist_bus cyc=%0d we=%b addr=%h exp=0/%h", cyc, mem_we, mem_addr, b_addr); end
        exp_bd = ref_mem[b_addr];
      end
      if (g == 2) begin
        checks++;
        if (mem_we !== p_we || mem_addr !== p_addr || (p_we && mem_wdata !== p_wdata)) begin
          errors++; $display("FAIL rnd_host_bus cyc=%0d we=%b addr=%h data=%h exp=%b/%h/%h", cyc, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wdata);
        end
        if (p_we) begin
          ref_mem[p_addr] = p_wdata;
          exp_hr = 8'h00;
        end else begin
          exp_hr = ref_mem[p_addr];
        end
        pend  = 1'b0;
        stall = 0;
      end else if (pend && !ack_phase && stall < 255) begin
        stall++;
      end
      ack_phase = (g == 2);
      tick();
      checks++;
      if (host_ack !== ack_phase) begin errors++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, host_ack, ack_phase); end
      checks++;
      if (host_rdata !== (ack_phase ? exp_hr : 8'h00)) begin errors++; $display("FAIL rnd_host_rdata cyc=%0d got=%h exp=%h", cyc, host_rdata, (ack_phase ? exp_hr : 8'h00)); end
      checks++;
      if (bist_data !== exp_bd) begin errors++; $display("FAIL rnd_bist_data cyc=%0d got=%h exp=%h", cyc, bist_data, exp_bd); end
      checks++;
      if (host_stall_cnt !== 8'(stall)) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, host_stall_cnt, stall); end
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    bist_active = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i]    = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem_rdata = 8'h00;
    test_reset();
    test_host_write();
    test_host_read();
    test_collision();
    test_starvation();
`ifdef BIST_MEM_HOST_LOCK_EN
    test_lock();
`endif
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
